// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: IF/ID/EX/MEM/WB sequencing with registered datapath strobes,
// bounded MEM wait with a sticky timeout flag, and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [2:0]  state,
  output logic        mem_err,
  output logic [31:0] instret
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t        st;
  logic [CW-1:0] wait_cnt;
  logic          zero_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_beq;
  logic [3:0] alu_dec;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_lw  = (opcode == 7'b0000011);
  assign is_sw  = (opcode == 7'b0100011);
  assign is_beq = (opcode == 7'b1100011);
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // funct3 only matters for ALU-class opcodes; SUB exists only as an R-type encoding
  always_comb begin
    alu_dec = ALU_ADD;
    if (is_beq) alu_dec = ALU_SUB;
    else if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_dec = (is_r && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_dec = ALU_AND;
        3'b110:  alu_dec = ALU_OR;
        3'b100:  alu_dec = ALU_XOR;
        3'b010:  alu_dec = ALU_SLT;
        3'b001:  alu_dec = ALU_SLL;
        3'b101:  alu_dec = instr[30] ? ALU_SRA : ALU_SRL;
        default: alu_dec = ALU_ADD;
      endcase
    end
  end

  assign state = st;
  assign PCSrc = (st == S_WB) && is_beq && zero_q;

  // Strobes are computed for the state being entered, so they are valid throughout it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IF;
      wait_cnt <= '0;
      zero_q   <= 1'b0;
      instret  <= '0;
      mem_err  <= 1'b0;
      ALUSrc   <= 1'b0;
      ALUCtrl  <= 4'b0000;
      RegWrite <= 1'b0;
      MemToReg <= 1'b0;
      loadPC   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      ALUSrc   <= is_i || is_lw || is_sw;
      ALUCtrl  <= alu_dec;
      RegWrite <= 1'b0;
      MemToReg <= 1'b0;
      loadPC   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      case (st)
        S_IF: st <= S_ID;
        S_ID: st <= S_EX;
        S_EX: begin
          if (is_lw || is_sw) begin
            st       <= S_MEM;
            wait_cnt <= '0;
            MemRead  <= is_lw;
            MemWrite <= is_sw;
          end else begin
            st       <= S_WB;
            zero_q   <= Zero;
            loadPC   <= 1'b1;
            RegWrite <= is_r || is_i;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            st       <= S_WB;
            loadPC   <= 1'b1;
            RegWrite <= is_lw;
            MemToReg <= is_lw;
          end else if (wait_cnt == WAIT_LAST) begin
            // abort: retire the instruction without writing back stale load data
            st       <= S_WB;
            loadPC   <= 1'b1;
            MemToReg <= is_lw;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            MemRead  <= is_lw;
            MemWrite <= is_sw;
          end
        end
        S_WB: begin
          st      <= S_IF;
          instret <= instret + 32'd1;
        end
        default: st <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction walks, MEM stall/timeout, reset in MEM, instret wrap.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst, Zero, mem_ready;
  logic [31:0] instr;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, mem_err;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;
  logic [31:0] instret;

  localparam logic [31:0] R_ADD  = 32'h002081B3;
  localparam logic [31:0] R_SUB  = 32'h402081B3;
  localparam logic [31:0] R_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_SRAI = 32'h4020D093;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] BEQ    = 32'h00208463;
  localparam logic [31:0] LW     = 32'h0000A183;
  localparam logic [31:0] SW     = 32'h0020A023;
  localparam logic [31:0] NOP    = 32'h0000007F;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl),
    .state(state), .mem_err(mem_err), .instret(instret)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_ret  = 0;
  int          cyc, nrd, nwr;
  logic [31:0] trace;
  logic        seen_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at an IF-cycle negedge; returns at the WB-cycle negedge.
  // mem_ready is raised in the (stall+1)-th MEM cycle; stall<0 never raises it.
  task automatic run_to_wb(input logic [31:0] ins, input int stall);
    int nmem = 0;
    instr = ins; mem_ready = 1'b0; cyc = 1; nrd = 0; nwr = 0;
    trace = 32'(state);
    while (state !== 3'd4 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      trace = (trace << 3) | 32'(state);
      if (state == 3'd3) begin
        nmem++;
        nrd += int'(MemRead);
        nwr += int'(MemWrite);
        if (nmem == stall + 1) mem_ready = 1'b1;
      end
    end
    mem_ready = 1'b0;
    chk("reach_wb", 32'(state), 32'd4);
  endtask

  task automatic next_if();
    @(negedge clk);
    n_ret++;
    chk("if_state", 32'(state), 32'd0);
    chk("if_loadpc", 32'(loadPC), 32'd0);
    chk("instret", instret, 32'(n_ret));
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic m2r, input logic pcs,
                        input logic asrc, input logic [3:0] alu);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'(rw));
    chk({tag, "_memtoreg"}, 32'(MemToReg), 32'(m2r));
    chk({tag, "_pcsrc"},    32'(PCSrc),    32'(pcs));
    chk({tag, "_alusrc"},   32'(ALUSrc),   32'(asrc));
    chk({tag, "_aluctrl"},  32'(ALUCtrl),  32'(alu));
    chk({tag, "_loadpc"},   32'(loadPC),   32'd1);
    chk({tag, "_memrw"},    32'({MemRead, MemWrite}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; instr = R_ADD; Zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_strobes", 32'({PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite}), 32'd0);
    chk("rst_aluctrl", 32'(ALUCtrl), 32'd0);
    chk("rst_instret", instret,      32'd0);
    chk("rst_memerr",  32'(mem_err), 32'd0);
    rst = 1'b0;
    chk("post_rst_if", 32'(state), 32'd0);

    // R-type ADD: IF,ID,EX,WB
    run_to_wb(R_ADD, 0);
    chk("add_trace", {20'd0, trace[11:0]}, {20'd0, 3'd0, 3'd1, 3'd2, 3'd4});
    chk("add_cycles", 32'(cyc), 32'd4);
    chk_wb("add", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
    chk("add_instret_wb", instret, 32'd0);
    next_if();

    // BEQ taken then not taken
    Zero = 1'b1;
    run_to_wb(BEQ, 0);
    chk_wb("beq_t", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110);
    next_if();
    Zero = 1'b0;
    run_to_wb(BEQ, 0);
    chk_wb("beq_nt", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    next_if();

    // ALU decode corners
    run_to_wb(R_SUB, 0);
    chk_wb("sub", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
    next_if();
    run_to_wb(R_AND, 0);
    chk_wb("and", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    next_if();
    run_to_wb(I_SRAI, 0);
    chk_wb("srai", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010);
    next_if();
    run_to_wb(I_ADDI, 0);
    chk_wb("addi_b30", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
    next_if();

    // LW with 3 stall cycles: 4 MEM cycles, 8 total
    run_to_wb(LW, 3);
    chk("lw_cycles", 32'(cyc), 32'd8);
    chk("lw_memread", 32'(nrd), 32'd4);
    chk("lw_memwrite", 32'(nwr), 32'd0);
    chk_wb("lw", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010);
    chk("lw_memerr", 32'(mem_err), 32'd0);
    next_if();

    // LW timeout: write-back suppressed
    run_to_wb(LW, -1);
    chk("lwto_cycles", 32'(cyc), 32'd20);
    chk("lwto_memread", 32'(nrd), 32'd16);
    chk_wb("lwto", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010);
    chk("lwto_memerr", 32'(mem_err), 32'd1);
    next_if();

    // SW timeout
    run_to_wb(SW, -1);
    chk("swto_cycles", 32'(cyc), 32'd20);
    chk("swto_memwrite", 32'(nwr), 32'd16);
    chk("swto_memread", 32'(nrd), 32'd0);
    chk_wb("swto", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    chk("swto_memerr", 32'(mem_err), 32'd1);
    next_if();
    chk("memerr_sticky", 32'(mem_err), 32'd1);

    // Reset during LW MEM
    instr = LW; mem_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("rmem_in_mem", 32'(state), 32'd3);
    chk("rmem_memread", 32'(MemRead), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmem_state", 32'(state), 32'd0);
    chk("rmem_strobes", 32'({PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite}), 32'd0);
    chk("rmem_instret", instret, 32'd0);
    chk("rmem_memerr", 32'(mem_err), 32'd0);
    seen_load = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen_load = seen_load | loadPC;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rmem_no_loadpc", 32'(seen_load), 32'd0);
    chk("rmem_if", 32'(state), 32'd0);

    // instret wrap with a NOP
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    chk("wrap_preset", instret, 32'hFFFF_FFFF);
    n_ret = -1;
    run_to_wb(NOP, 0);
    chk("nop_cycles", 32'(cyc), 32'd4);
    chk_wb("nop", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    next_if();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
